btn_debouncer: RTL and testbench



---
 rtl/btn_debouncer_pkg.sv | 18 +
 rtl/btn_debouncer_channel.sv | 64 ++++++
 rtl/btn_debouncer.sv | 32 +++
 tb/tb_btn_debouncer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared constants for the push-button front end and the operand/opcode
// load stage that consumes its outputs.
package btn_debouncer_pkg;

    // Board clock and the default debounce window (10 ms at 100 MHz).
    localparam int CLK_FREQ_HZ           = 100_000_000;
    localparam int DEBOUNCE_MS           = 10;
    localparam int DEFAULT_STABLE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_NB_CNT        = 20;
    localparam int DEFAULT_NB_BTN        = 3;

    // Button roles, shared with the load stage so both sides agree on
    // which bit loads which register.
    localparam int BTN_LOAD_A  = 0;
    localparam int BTN_LOAD_B  = 1;
    localparam int BTN_LOAD_OP = 2;

endpackage : btn_debouncer_pkg

// File: rtl/btn_debouncer_channel.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a one-cycle press strobe.
module debounce_channel
    import btn_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int NB_CNT        = DEFAULT_NB_CNT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    // Terminal count: the level flips on the STABLE_CYCLES-th consecutive
    // mismatch, so the counter never needs to go past STABLE_CYCLES-1.
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(STABLE_CYCLES - 1);

    logic              sync_1;
    logic              sync_2;
    logic [NB_CNT-1:0] count;
    logic              level;
    logic              pulse;

    // Two-flop chain bringing the raw asynchronous input into the clock
    // domain; only sync_2 is ever looked at by the filter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_btn;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive disagreements between the synchronised input and
    // the debounced level; any agreement restarts the window, and a full
    // window flips the level. The strobe is registered alongside the level
    // so it lines up with the first high cycle and only fires on presses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                count <= '0;
                level <= sync_2;
                pulse <= sync_2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign o_level = level;
    assign o_pulse = pulse;

endmodule : debounce_channel

// File: rtl/btn_debouncer.sv
// Push-button conditioning front end: NB_BTN independent debounce channels
// producing clean levels and single-cycle press pulses for the load stage.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int NB_BTN        = DEFAULT_NB_BTN,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int NB_CNT        = DEFAULT_NB_CNT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    // Channels share nothing but clock and reset, so simultaneous presses
    // are handled in parallel with no priority between buttons.
    for (genvar n = 0; n < NB_BTN; n++) begin : g_channel
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .NB_CNT       (NB_CNT)
        ) u_channel (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_btn  (i_btn[n]),
            .o_level(o_btn_level[n]),
            .o_pulse(o_btn_pulse[n])
        );
    end

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with a 4-cycle debounce window, so every
// press or release shows up on the outputs after the 6th sampling edge.
module tb_btn_debouncer;

    localparam int NB_BTN = 3;

    logic              i_clk;
    logic              i_reset;
    logic [NB_BTN-1:0] i_btn;
    logic [NB_BTN-1:0] o_btn_level;
    logic [NB_BTN-1:0] o_btn_pulse;

    int total;
    int bad;

    btn_debouncer #(
        .NB_BTN       (NB_BTN),
        .STABLE_CYCLES(4),
        .NB_CNT       (3)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_btn      (i_btn),
        .o_btn_level(o_btn_level),
        .o_btn_pulse(o_btn_pulse)
    );

    // 10 ns free-running clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(input logic [NB_BTN-1:0] btn);
        i_btn = btn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Stimulus and checks: edge j is the j-th rising edge after the phase's
    // first input change, with outputs sampled 1 ns after it.
    initial begin
        logic [NB_BTN-1:0] bounce_seq [4];
        logic [NB_BTN-1:0] b;
        total = 0;
        bad   = 0;
        bounce_seq[0] = 3'b011;
        bounce_seq[1] = 3'b001;
        bounce_seq[2] = 3'b011;
        bounce_seq[3] = 3'b001;

        // Reset holds everything low even with all buttons pressed.
        i_reset = 1'b1;
        applyStimulus(3'b111);
        repeat (3) tick();
        checkOutput("reset level", 32'(o_btn_level), 32'h0);
        checkOutput("reset pulse", 32'(o_btn_pulse), 32'h0);
        applyStimulus(3'b000);
        i_reset = 1'b0;
        repeat (3) tick();
        checkOutput("idle level", 32'(o_btn_level), 32'h0);

        // Clean press on button 0.
        applyStimulus(3'b001);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput($sformatf("press level e%0d", j), 32'(o_btn_level), (j >= 5) ? 32'h1 : 32'h0);
            checkOutput($sformatf("press pulse e%0d", j), 32'(o_btn_pulse), (j == 5) ? 32'h1 : 32'h0);
        end

        // Bounce on button 1 (1,0,1,0 then held 1); final 1 is sampled at
        // edge 4 so the level rises after edge 9.
        for (int j = 0; j < 12; j++) begin
            b = (j < 4) ? bounce_seq[j] : 3'b011;
            applyStimulus(b);
            tick();
            checkOutput($sformatf("bounce level e%0d", j), 32'(o_btn_level), (j >= 9) ? 32'h3 : 32'h1);
            checkOutput($sformatf("bounce pulse e%0d", j), 32'(o_btn_pulse), (j == 9) ? 32'h2 : 32'h0);
        end

        // Three-cycle glitch on button 2 is one cycle short of a flip.
        for (int j = 0; j < 10; j++) begin
            applyStimulus((j < 3) ? 3'b111 : 3'b011);
            tick();
            checkOutput($sformatf("glitch level e%0d", j), 32'(o_btn_level), 32'h3);
            checkOutput($sformatf("glitch pulse e%0d", j), 32'(o_btn_pulse), 32'h0);
        end

        // Release buttons 0 and 1: level drops after edge 5, no pulse.
        applyStimulus(3'b000);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput($sformatf("release level e%0d", j), 32'(o_btn_level), (j >= 5) ? 32'h0 : 32'h3);
            checkOutput($sformatf("release pulse e%0d", j), 32'(o_btn_pulse), 32'h0);
        end

        // Buttons 0 and 2 together.
        applyStimulus(3'b101);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput($sformatf("simul level e%0d", j), 32'(o_btn_level), (j >= 5) ? 32'h5 : 32'h0);
            checkOutput($sformatf("simul pulse e%0d", j), 32'(o_btn_pulse), (j == 5) ? 32'h5 : 32'h0);
        end

        // Press button 1 while 0 and 2 are high; after edge 3 its counter
        // holds 2. Reset between edges must clear outputs immediately.
        applyStimulus(3'b111);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput($sformatf("premid level e%0d", j), 32'(o_btn_level), 32'h5);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("async reset level", 32'(o_btn_level), 32'h0);
        checkOutput("async reset pulse", 32'(o_btn_pulse), 32'h0);
        #1;
        i_reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput($sformatf("post-reset level e%0d", j), 32'(o_btn_level), (j >= 5) ? 32'h7 : 32'h0);
            checkOutput($sformatf("post-reset pulse e%0d", j), 32'(o_btn_pulse), (j == 5) ? 32'h7 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_btn_debouncer
